// File: rtl/hazard_ctrl_if.sv
// Signal bundle between the pipeline datapath and the hazard controller.
// master drives the ID/EX hazard inputs; slave is the controller itself.
interface hazard_ctrl_if;
  logic [4:0]  i_id_rs;
  logic [4:0]  i_id_rt;
  logic        i_id_use_rt;
  logic [4:0]  i_ex_rd;
  logic        i_ex_GPRWr;
  logic        i_ex_lw;
  logic        i_flush;
  logic        o_pc_wr;
  logic        o_ifid_wr;
  logic        o_idex_bubble;
  logic [1:0]  o_fwdA;
  logic [1:0]  o_fwdB;
  logic [15:0] o_stall_cnt;

  modport master (
    output i_id_rs, i_id_rt, i_id_use_rt, i_ex_rd, i_ex_GPRWr, i_ex_lw, i_flush,
    input  o_pc_wr, o_ifid_wr, o_idex_bubble, o_fwdA, o_fwdB, o_stall_cnt
  );

  modport slave (
    input  i_id_rs, i_id_rt, i_id_use_rt, i_ex_rd, i_ex_GPRWr, i_ex_lw, i_flush,
    output o_pc_wr, o_ifid_wr, o_idex_bubble, o_fwdA, o_fwdB, o_stall_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Load-use stall, flush bubbling and registered forward-select generation
// for a five-stage pipeline.
module hazard_ctrl (
  input  logic          clk,
  input  logic          rst,
  hazard_ctrl_if.slave  bus
);

  typedef enum logic [0:0] {StRun, StBubble} state_e;

  state_e      r_state;
  state_e      w_state_nxt;
  logic [4:0]  r_mem_rd;
  logic        r_mem_wr;
  logic [4:0]  r_wb_rd;
  logic        r_wb_wr;
  logic [1:0]  r_fwd_a;
  logic [1:0]  r_fwd_b;
  logic [15:0] r_stall_cnt;
  logic        w_luh;
  logic        w_pc_wr;
  logic        w_ifid_wr;
  logic        w_bubble;
  logic        w_stall;
  logic        w_unused_wb;

  // EX/MEM result beats MEM/WB; a load still in EX has no result yet.
  function automatic logic [1:0] fwd_sel(input logic [4:0] src, input logic [4:0] ex_rd,
                                         input logic ex_wr, input logic ex_lw,
                                         input logic [4:0] mem_rd, input logic mem_wr);
    if (ex_wr && (ex_rd != 5'd0) && (ex_rd == src) && !ex_lw) begin
      return 2'b01;
    end else if (mem_wr && (mem_rd != 5'd0) && (mem_rd == src)) begin
      return 2'b10;
    end
    return 2'b00;
  endfunction

  assign w_luh = bus.i_ex_lw & bus.i_ex_GPRWr & (bus.i_ex_rd != 5'd0) &
                 ((bus.i_ex_rd == bus.i_id_rs) |
                  (bus.i_id_use_rt & (bus.i_ex_rd == bus.i_id_rt)));

  always_comb begin
    w_state_nxt = r_state;
    w_pc_wr     = 1'b1;
    w_ifid_wr   = 1'b1;
    w_bubble    = 1'b0;
    w_stall     = 1'b0;
    if (!rst) begin
      if (bus.i_flush) begin
        w_bubble    = 1'b1;
        w_state_nxt = StRun;
      end else begin
        unique case (r_state)
          StRun: begin
            if (w_luh) begin
              w_pc_wr     = 1'b0;
              w_ifid_wr   = 1'b0;
              w_bubble    = 1'b1;
              w_stall     = 1'b1;
              w_state_nxt = StBubble;
            end
          end
          StBubble: w_state_nxt = StRun;
          default:  w_state_nxt = StRun;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StRun;
      r_mem_rd    <= 5'd0;
      r_mem_wr    <= 1'b0;
      r_wb_rd     <= 5'd0;
      r_wb_wr     <= 1'b0;
      r_fwd_a     <= 2'b00;
      r_fwd_b     <= 2'b00;
      r_stall_cnt <= 16'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_mem_rd <= bus.i_ex_rd;
      r_mem_wr <= bus.i_ex_GPRWr;
      r_wb_rd  <= r_mem_rd;
      r_wb_wr  <= r_mem_wr;
      if (w_bubble) begin
        r_fwd_a <= 2'b00;
        r_fwd_b <= 2'b00;
      end else begin
        r_fwd_a <= fwd_sel(bus.i_id_rs, bus.i_ex_rd, bus.i_ex_GPRWr, bus.i_ex_lw,
                           r_mem_rd, r_mem_wr);
        r_fwd_b <= bus.i_id_use_rt ?
                   fwd_sel(bus.i_id_rt, bus.i_ex_rd, bus.i_ex_GPRWr, bus.i_ex_lw,
                           r_mem_rd, r_mem_wr) : 2'b00;
      end
      if (w_stall && (r_stall_cnt != 16'hFFFF)) begin
        r_stall_cnt <= r_stall_cnt + 16'd1;
      end
    end
  end

  // WB stage is tracked but never a forward source: the regfile writes before it reads.
  assign w_unused_wb = ^{r_wb_rd, r_wb_wr};

  assign bus.o_pc_wr       = w_pc_wr;
  assign bus.o_ifid_wr     = w_ifid_wr;
  assign bus.o_idex_bubble = w_bubble;
  assign bus.o_fwdA        = r_fwd_a;
  assign bus.o_fwdB        = r_fwd_b;
  assign bus.o_stall_cnt   = r_stall_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized and directed bench for hazard_ctrl against a behavioural reference.
module tb_hazard_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hazard_ctrl_if u_if ();

  hazard_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Literal expectations for the current cycle; -1 means no literal check.
  int lit_pc   = -1;
  int lit_bub  = -1;
  int lit_fa   = -1;
  int lit_fb   = -1;
  int lit_cnt  = -1;
  logic do_preload = 1'b0;

  // Reference: "last cycle's EX writer" plus a stall flag and a counter.
  logic        m_in_bubble = 1'b0;
  logic [4:0]  m_prev_rd   = 5'd0;
  logic        m_prev_wr   = 1'b0;
  logic [1:0]  m_fwd_a     = 2'b00;
  logic [1:0]  m_fwd_b     = 2'b00;
  logic [15:0] m_cnt       = 16'd0;

  function automatic logic ref_luh();
    logic [4:0] d;
    d = u_if.i_ex_rd;
    if (!(u_if.i_ex_lw && u_if.i_ex_GPRWr) || d == 5'd0) return 1'b0;
    return (d == u_if.i_id_rs) || (u_if.i_id_use_rt && d == u_if.i_id_rt);
  endfunction

  function automatic logic [1:0] ref_src(input logic [4:0] r);
    if (r == 5'd0) return 2'd0;
    if (u_if.i_ex_GPRWr && !u_if.i_ex_lw && u_if.i_ex_rd == r) return 2'd1;
    if (m_prev_wr && m_prev_rd == r) return 2'd2;
    return 2'd0;
  endfunction

  always @(posedge clk) begin
    logic stall;
    logic kill;
    if (rst) begin
      m_in_bubble <= 1'b0;
      m_prev_rd   <= 5'd0;
      m_prev_wr   <= 1'b0;
      m_fwd_a     <= 2'd0;
      m_fwd_b     <= 2'd0;
      m_cnt       <= 16'd0;
    end else begin
      stall = !u_if.i_flush && !m_in_bubble && ref_luh();
      kill  = u_if.i_flush || stall;
      m_in_bubble <= stall;
      if (do_preload) m_cnt <= 16'hFFFE;
      else if (stall) m_cnt <= (m_cnt == 16'hFFFF) ? m_cnt : m_cnt + 16'd1;
      m_fwd_a   <= kill ? 2'd0 : ref_src(u_if.i_id_rs);
      m_fwd_b   <= (kill || !u_if.i_id_use_rt) ? 2'd0 : ref_src(u_if.i_id_rt);
      m_prev_rd <= u_if.i_ex_rd;
      m_prev_wr <= u_if.i_ex_GPRWr;
    end
  end

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic e_pc;
    logic e_bub;
    e_pc  = 1'b1;
    e_bub = 1'b0;
    if (!rst) begin
      if (u_if.i_flush) e_bub = 1'b1;
      else if (!m_in_bubble && ref_luh()) begin
        e_pc  = 1'b0;
        e_bub = 1'b1;
      end
    end
    chk("pc_wr", 16'(u_if.o_pc_wr), 16'(e_pc));
    chk("ifid_wr", 16'(u_if.o_ifid_wr), 16'(e_pc));
    chk("idex_bubble", 16'(u_if.o_idex_bubble), 16'(e_bub));
    chk("fwdA", 16'(u_if.o_fwdA), 16'(m_fwd_a));
    chk("fwdB", 16'(u_if.o_fwdB), 16'(m_fwd_b));
    chk("stall_cnt", u_if.o_stall_cnt, m_cnt);
    if (lit_pc >= 0)  chk("lit_pc_wr", 16'(u_if.o_pc_wr), 16'(lit_pc));
    if (lit_bub >= 0) chk("lit_bubble", 16'(u_if.o_idex_bubble), 16'(lit_bub));
    if (lit_fa >= 0)  chk("lit_fwdA", 16'(u_if.o_fwdA), 16'(lit_fa));
    if (lit_fb >= 0)  chk("lit_fwdB", 16'(u_if.o_fwdB), 16'(lit_fb));
    if (lit_cnt >= 0) chk("lit_stall_cnt", u_if.o_stall_cnt, 16'(lit_cnt));
  end

  task automatic step(input logic r, input logic [4:0] rs, input logic [4:0] rt,
                      input logic urt, input logic [4:0] exrd, input logic exwr,
                      input logic exlw, input logic fl,
                      input int lpc = -1, input int lbub = -1, input int lfa = -1,
                      input int lfb = -1, input int lcnt = -1);
    @(posedge clk);
    #1;
    rst              = r;
    u_if.i_id_rs     = rs;
    u_if.i_id_rt     = rt;
    u_if.i_id_use_rt = urt;
    u_if.i_ex_rd     = exrd;
    u_if.i_ex_GPRWr  = exwr;
    u_if.i_ex_lw     = exlw;
    u_if.i_flush     = fl;
    lit_pc  = lpc;
    lit_bub = lbub;
    lit_fa  = lfa;
    lit_fb  = lfb;
    lit_cnt = lcnt;
  endtask

  initial begin
    u_if.i_id_rs     = 5'd0;
    u_if.i_id_rt     = 5'd0;
    u_if.i_id_use_rt = 1'b0;
    u_if.i_ex_rd     = 5'd0;
    u_if.i_ex_GPRWr  = 1'b0;
    u_if.i_ex_lw     = 1'b0;
    u_if.i_flush     = 1'b0;

    // Reset holds outputs benign even with a live hazard on the inputs.
    step(1, 8, 2, 1, 8, 1, 1, 0, 1, 0, 0, 0, 0);
    // lw $8 in EX, add $9,$8,$2 in ID: one stall, then MEM/WB forward.
    step(0, 8, 2, 1, 8, 1, 1, 0, 0, 1, -1, -1, 0);
    step(0, 8, 2, 1, 0, 0, 0, 0, 1, 0, 0, -1, 1);
    // ALU result forward on rt: add $5 in EX, sub $6,$7,$5 in ID.
    step(0, 7, 5, 1, 5, 1, 0, 0, 1, 0, 2, 0);
    step(0, 0, 0, 0, 4, 1, 0, 0, -1, -1, 0, 1);
    // $4 in both EX and MEM: EX/MEM wins, then MEM/WB alone.
    step(0, 4, 0, 0, 4, 1, 0, 0, -1, -1, 0, 0);
    step(0, 4, 0, 0, 0, 0, 0, 0, -1, -1, 1);
    // lw $0 never stalls; rt without use_rt never forwards.
    step(0, 0, 0, 1, 0, 1, 1, 0, 1, 0, 2);
    step(0, 1, 3, 0, 3, 1, 0, 0, 1, 0, 0, 0);
    step(0, 3, 3, 1, 0, 0, 0, 0, -1, -1, 0, 0);
    // Flush beats load-use: bubble without stall, FSM stays in RUN.
    step(0, 8, 2, 1, 8, 1, 1, 1, 1, 1, 2, 2, 1);
    step(0, 8, 2, 1, 8, 1, 1, 0, 0, 1, 0, 0, 1);
    step(0, 8, 2, 1, 0, 0, 0, 0, 1, 0, -1, -1, 2);

    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 63) == 0),
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           5'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 7) == 0));
    end

    // Preload the counter near the top instead of replaying 65534 hazards.
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    do_preload = 1'b1;
    @(posedge clk);
    #1;
    force dut.r_stall_cnt = 16'hFFFE;
    release dut.r_stall_cnt;
    do_preload = 1'b0;
    step(0, 8, 2, 1, 8, 1, 1, 0, 0, 1, -1, -1, 16'hFFFE);
    step(0, 8, 2, 1, 0, 0, 0, 0, 1, 0, -1, -1, 16'hFFFF);
    step(0, 8, 2, 1, 8, 1, 1, 0, 0, 1, -1, -1, 16'hFFFF);
    step(0, 8, 2, 1, 0, 0, 0, 0, 1, 0, -1, -1, 16'hFFFF);

    // Reset landing in BUBBLE leaves no residual stall.
    step(0, 8, 2, 1, 8, 1, 1, 0, 0, 1);
    step(1, 8, 2, 1, 8, 1, 1, 0, 1, 0);
    step(0, 8, 2, 1, 8, 1, 1, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1);

    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-high reset, with the ports listed below (clock and reset first).
REQ-002 clk  input  1  pipeline clock; all state updates on posedge clk.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 i_id_rs  input  5  rs field of the instruction in ID.
REQ-005 i_id_rt  input  5  rt field of the instruction in ID.
REQ-006 i_id_use_rt  input  1  1 when the ID instruction reads rt as a source; R-type and sw set it.
REQ-007 i_ex_rd, i_ex_GPRWr, i_ex_lw  input  5/1/1  destination, write enable and load flag of the instruction in EX, taken from the ID/EX register outputs.
REQ-008 i_flush  input  1  branch/jump taken; kill the instructions in IF and ID.
REQ-009 o_pc_wr  output  1  PC write enable.
REQ-010 o_ifid_wr  output  1  IF/ID write enable.
REQ-011 o_idex_bubble  output  1  forces the ID/EX signals bus to 8'h00 and i_lw to 0 at the next edge.
REQ-012 o_fwdA, o_fwdB  output  2  registered EX operand select: 00 regfile, 01 EX/MEM result, 10 MEM/WB result; 11 is never driven.
REQ-013 o_stall_cnt  output  16  saturating count of load-use stall cycles.

Function
REQ-014 Internal shadow pipeline: mem_rd/mem_wr SHALL load i_ex_rd/i_ex_GPRWr each cycle; wb_rd/wb_wr SHALL load mem_rd/mem_wr each cycle. These registers are never gated.
REQ-015 Load-use hazard (combinational), luh = i_ex_lw & i_ex_GPRWr & (i_ex_rd!=0) & ((i_ex_rd==i_id_rs) | (i_id_use_rt & i_ex_rd==i_id_rt)).
REQ-016 FSM states: RUN and BUBBLE. RUN -> BUBBLE when luh & !i_flush. BUBBLE -> RUN unconditionally after one cycle.
REQ-017 In RUN with luh & !i_flush: o_pc_wr=0, o_ifid_wr=0, o_idex_bubble=1 in the same cycle (combinational).
REQ-018 In BUBBLE: o_pc_wr=1, o_ifid_wr=1, o_idex_bubble=0; the held instruction advances. The maximum stall per load is exactly 1 cycle.
REQ-019 i_flush=1 has priority over luh: o_pc_wr=1, o_ifid_wr=1, o_idex_bubble=1, the next state is RUN, and the stall counter does not increment.
REQ-020 Forward select, registered at posedge and applying to the instruction entering EX. Source X is rs (for A) or rt (for B).
- 01 if i_ex_GPRWr & i_ex_rd!=0 & i_ex_rd==X & !i_ex_lw.
- Otherwise 10 if mem_wr & mem_rd!=0 & mem_rd==X.
- Otherwise 00.
- EX/MEM has priority over MEM/WB when both match.
REQ-021 o_fwdB SHALL follow REQ-020 only when i_id_use_rt=1; otherwise it is 00.
REQ-022 When o_idex_bubble=1 (stall or flush), o_fwdA and o_fwdB SHALL load 00 at that edge.
REQ-023 A load consumer released from BUBBLE SHALL receive 10, because the load now sits in MEM (mem_rd matches).
REQ-024 Register $0 SHALL never cause a stall or a forward.
REQ-025 Three-stage-back dependencies are not forwarded; the register file writes before it reads within a cycle.
REQ-026 o_stall_cnt SHALL increment by 1 on each RUN->BUBBLE transition and saturate at 16'hFFFF (no wrap).

Reset
REQ-027 While rst=1 at posedge, the following SHALL take their reset values: FSM=RUN, mem_rd/wb_rd=0, mem_wr/wb_wr=0, o_fwdA=o_fwdB=00, o_stall_cnt=0.
REQ-028 While rst=1, o_pc_wr=1, o_ifid_wr=1 and o_idex_bubble=0, regardless of the other inputs.
REQ-029 A reset asserted in BUBBLE SHALL return the FSM to RUN at that edge; no residual stall remains.

Verification
REQ-030 Load-use: EX = lw $8 (GPRWr=1, lw=1); ID = add $9,$8,$2 (use_rt=1).
- Cycle 0: pc_wr=0, ifid_wr=0, bubble=1.
- Cycle 1: BUBBLE, pc_wr=1.
- Cycle 2: fwdA=10.
- stall_cnt=1.
REQ-031 ALU forward: EX = add $5 (GPRWr=1, lw=0); ID = sub $6,$7,$5 -> no stall; next cycle fwdA=00, fwdB=01.
REQ-032 Priority: mem_rd=$4 and EX rd=$4 both writing; ID reads rs=$4 -> fwdA=01.
REQ-033 $0 and use_rt gating:
- EX = lw $0, ID reads $0 -> no stall, fwd=00.
- ID with use_rt=0 and rt matching EX rd -> fwdB=00.
REQ-034 Flush during hazard: luh=1 and i_flush=1 -> bubble=1, pc_wr=1, state stays RUN, stall_cnt unchanged, next fwdA/fwdB=00.
REQ-035 Saturation and reset:
- Preload via 65535 hazards; one more hazard -> stall_cnt stays FFFF.
- rst=1 in BUBBLE -> next cycle RUN, cnt=0, fwd=00.
